// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and requests one word at a time
// from instruction memory over req/gnt/rvalid. Returned words are queued
// in a small FIFO and handed to decode as {pc, inst} under valid/ready.
// A redirect flushes the queue, and any response still in flight is dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [31:0]        pc_r, pc_s;
    logic [31:0]        tag_r, tag_s;
    logic               req_r, req_s;
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [31:0]        inst_mem_r [DEPTH];
    logic [31:0]        pc_mem_r   [DEPTH];
    logic               valid_r, valid_s;
    logic [31:0]        head_inst_r, head_inst_s;
    logic [31:0]        head_pc_r, head_pc_s;
    logic               gnt_s;
    logic               push_s;
    logic               pop_s;
    logic               reserved_s;

    // A grant only counts while a request is actually being driven.
    assign gnt_s = req_r & imem_gnt;
    // Decode pops the head unless a redirect is flushing it this cycle.
    assign pop_s = valid_r & id_ready & ~redirect;

    // Next-state logic: fetch FSM, PC, FIFO pointers and the next head.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        tag_s      = tag_r;
        push_s     = 1'b0;
        reserved_s = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (redirect) begin
                    pc_s    = redirect_pc & 32'hFFFF_FFFC;
                    // A simultaneous grant leaves a response in flight.
                    state_s = gnt_s ? ST_DROP : ST_REQ;
                end else if (gnt_s) begin
                    tag_s   = pc_r;
                    pc_s    = pc_r + 32'd4;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_s    = redirect_pc & 32'hFFFF_FFFC;
                    state_s = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    push_s  = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pc_s = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    pc_s = pc_r;
                end
                state_s = imem_rvalid ? ST_REQ : ST_DROP;
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase

        if (redirect) begin
            wr_ptr_s = {PTR_W{1'b0}};
            rd_ptr_s = {PTR_W{1'b0}};
            count_s  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_s = wr_ptr_r + PTR_W'(push_s);
            rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
            count_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end

        // An outstanding request holds a slot so its push always fits.
        if (state_s == ST_WAIT) begin
            reserved_s = 1'b1;
        end else begin
            reserved_s = 1'b0;
        end
        req_s = (state_s == ST_REQ) &&
                ((count_s + CNT_W'(reserved_s)) < CNT_W'(DEPTH));

        // Next head: the word being pushed if it lands at the read slot.
        if (count_s == {CNT_W{1'b0}}) begin
            valid_s     = 1'b0;
            head_inst_s = NOP;
            head_pc_s   = 32'h0000_0000;
        end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            valid_s     = 1'b1;
            head_inst_s = imem_rdata;
            head_pc_s   = tag_r;
        end else begin
            valid_s     = 1'b1;
            head_inst_s = inst_mem_r[rd_ptr_s];
            head_pc_s   = pc_mem_r[rd_ptr_s];
        end
    end

    // State, pointer and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_REQ;
            pc_r        <= RESET_PC;
            tag_r       <= 32'h0000_0000;
            req_r       <= 1'b0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            head_inst_r <= NOP;
            head_pc_r   <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            tag_r       <= tag_s;
            req_r       <= req_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            valid_r     <= valid_s;
            head_inst_r <= head_inst_s;
            head_pc_r   <= head_pc_s;
        end
    end

    // FIFO storage; written at the write pointer on each accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= NOP;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            inst_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= tag_r;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign id_valid  = valid_r;
    assign id_inst   = head_inst_r;
    assign id_pc     = head_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for streaming, back-pressure,
// grant stalls and redirects, plus a hand sequence for PC wrap and
// asynchronous reset in the middle of a fetch.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    logic        w_rst_n;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_inst;
    logic [31:0] w_pc;

    int pass_cnt;
    int total_cnt;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .id_valid(w_valid), .id_ready(w_ready),
        .id_inst(w_inst), .id_pc(w_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einst);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redir = rdr; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.epc = epc; v.einst = einst;
        vq.push_back(v);
    endtask

    // Row whose expected decode side is empty.
    task automatic adde(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rdr, input logic [31:0] rpc,
                        input logic ereq, input logic [31:0] eaddr);
        add(g, rv, rd, rdy, rdr, rpc, ereq, eaddr, 1'b0, 32'h0, NOP);
    endtask

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    endtask

    task automatic reset_main(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rst_req"},   {31'h0, imem_req}, 32'h0);
        chk({tag, "_rst_addr"},  imem_addr, 32'h0);
        chk({tag, "_rst_valid"}, {31'h0, id_valid}, 32'h0);
        chk({tag, "_rst_inst"},  id_inst, NOP);
        chk({tag, "_rst_pc"},    id_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            imem_gnt = vq[i].gnt; imem_rvalid = vq[i].rvalid; imem_rdata = vq[i].rdata;
            id_ready = vq[i].ready; redirect = vq[i].redir; redirect_pc = vq[i].rpc;
            chk($sformatf("%s[%0d].req", tag, i),   {31'h0, imem_req}, {31'h0, vq[i].ereq});
            chk($sformatf("%s[%0d].addr", tag, i),  imem_addr, vq[i].eaddr);
            chk($sformatf("%s[%0d].valid", tag, i), {31'h0, id_valid}, {31'h0, vq[i].evalid});
            chk($sformatf("%s[%0d].pc", tag, i),    id_pc, vq[i].epc);
            chk($sformatf("%s[%0d].inst", tag, i),  id_inst, vq[i].einst);
            @(posedge clk); #1;
        end
        idle_inputs();
        vq.delete();
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        idle_inputs();
        rst_n = 1'b0;
        w_rst_n = 1'b0; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
        w_redirect = 1'b0; w_redirect_pc = 32'h0; w_ready = 1'b0;

        // Streaming with a one-cycle memory and decode always ready.
        reset_main("stream");
        adde(0, 0, 32'h0,    1, 0, 32'h0, 0, 32'h0);
        adde(1, 0, 32'h0,    1, 0, 32'h0, 1, 32'h0);
        adde(0, 1, mw(32'h0),1, 0, 32'h0, 0, 32'h4);
        add (1, 0, 32'h0,    1, 0, 32'h0, 1, 32'h4, 1, 32'h0, mw(32'h0));
        adde(0, 1, mw(32'h4),1, 0, 32'h0, 0, 32'h8);
        add (1, 0, 32'h0,    1, 0, 32'h0, 1, 32'h8, 1, 32'h4, mw(32'h4));
        adde(0, 1, mw(32'h8),1, 0, 32'h0, 0, 32'hC);
        add (1, 0, 32'h0,    1, 0, 32'h0, 1, 32'hC, 1, 32'h8, mw(32'h8));
        adde(0, 1, mw(32'hC),1, 0, 32'h0, 0, 32'h10);
        add (0, 0, 32'h0,    1, 0, 32'h0, 1, 32'h10, 1, 32'hC, mw(32'hC));
        run_table("stream");

        // Back-pressure, grant stall, redirect in WAIT, redirect with grant.
        reset_main("flow");
        adde(0, 0, 32'h0,     0, 0, 32'h0,   0, 32'h0);
        adde(1, 0, 32'h0,     0, 0, 32'h0,   1, 32'h0);
        adde(0, 1, mw(32'h0), 0, 0, 32'h0,   0, 32'h4);
        add (1, 0, 32'h0,     0, 0, 32'h0,   1, 32'h4, 1, 32'h0, mw(32'h0));
        add (0, 1, mw(32'h4), 0, 0, 32'h0,   0, 32'h8, 1, 32'h0, mw(32'h0));
        add (1, 0, 32'h0,     0, 0, 32'h0,   0, 32'h8, 1, 32'h0, mw(32'h0));
        add (1, 0, 32'h0,     0, 0, 32'h0,   0, 32'h8, 1, 32'h0, mw(32'h0));
        add (0, 0, 32'h0,     1, 0, 32'h0,   0, 32'h8, 1, 32'h0, mw(32'h0));
        add (0, 0, 32'h0,     1, 0, 32'h0,   1, 32'h8, 1, 32'h4, mw(32'h4));
        adde(0, 0, 32'h0,     1, 0, 32'h0,   1, 32'h8);
        adde(0, 0, 32'h0,     1, 0, 32'h0,   1, 32'h8);
        adde(1, 0, 32'h0,     1, 0, 32'h0,   1, 32'h8);
        adde(0, 1, mw(32'h8), 1, 0, 32'h0,   0, 32'hC);
        add (1, 0, 32'h0,     1, 0, 32'h0,   1, 32'hC, 1, 32'h8, mw(32'h8));
        adde(0, 1, mw(32'hC), 1, 0, 32'h0,   0, 32'h10);
        add (1, 0, 32'h0,     1, 0, 32'h0,   1, 32'h10, 1, 32'hC, mw(32'hC));
        adde(0, 0, 32'h0,     1, 1, 32'h103, 0, 32'h14);
        adde(0, 1, mw(32'h10),1, 0, 32'h0,   0, 32'h100);
        adde(1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 1, 32'h100);
        adde(0, 1, mw(32'h100), 1, 0, 32'h0, 0, 32'h104);
        add (1, 0, 32'h0,     1, 1, 32'h200, 1, 32'h104, 1, 32'h100, mw(32'h100));
        adde(0, 1, mw(32'h104), 1, 0, 32'h0, 0, 32'h200);
        adde(1, 0, 32'h0,     1, 0, 32'h0,   1, 32'h200);
        adde(0, 1, mw(32'h200), 1, 0, 32'h0, 0, 32'h204);
        add (0, 0, 32'h0,     1, 0, 32'h0,   1, 32'h204, 1, 32'h200, mw(32'h200));
        run_table("flow");

        // PC wrap and asynchronous reset during WAIT.
        @(posedge clk); #1;
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_req", {31'h0, w_req}, 32'h0);
        w_rst_n = 1'b1;
        chk("wrap_c0_req", {31'h0, w_req}, 32'h0);
        @(posedge clk); #1;
        chk("wrap_c1_req", {31'h0, w_req}, 32'h1);
        chk("wrap_c1_addr", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1'b1;
        @(posedge clk); #1;
        w_gnt = 1'b0;
        chk("wrap_c2_addr", w_addr, 32'h0);
        chk("wrap_c2_req", {31'h0, w_req}, 32'h0);
        w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        w_rvalid = 1'b0;
        chk("wrap_c3_valid", {31'h0, w_valid}, 32'h1);
        chk("wrap_c3_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_c3_inst", w_inst, 32'h1234_5678);
        w_gnt = 1'b1;
        @(posedge clk); #1;
        w_gnt = 1'b0;
        chk("wrap_c4_addr", w_addr, 32'h4);
        #2;
        w_rst_n = 1'b0;
        #1;
        chk("async_req", {31'h0, w_req}, 32'h0);
        chk("async_addr", w_addr, 32'hFFFF_FFFC);
        chk("async_valid", {31'h0, w_valid}, 32'h0);
        chk("async_inst", w_inst, NOP);
        chk("async_pc", w_pc, 32'h0);
        @(posedge clk); #1;
        w_rst_n = 1'b1;
        w_rvalid = 1'b1; w_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        w_rvalid = 1'b0;
        chk("stale_valid", {31'h0, w_valid}, 32'h0);
        chk("stale_req", {31'h0, w_req}, 32'h1);
        chk("stale_addr", w_addr, 32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the SCPU datapath; sits directly upstream of decode and the immediate generator.
- Owns the PC register and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents {pc, inst} to decode with a valid/ready handshake.
- Accepts branch/jump redirects, flushes buffered instructions and discards any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 2, instruction buffer entries (power of two, >= 2).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  memory accepts request this cycle (only meaningful while imem_req=1)
- imem_rvalid  in  1  response data valid; at least 1 cycle after the gnt
- imem_rdata  in  32  fetched instruction
- redirect  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  new fetch target
- id_valid  out  1  buffer head valid toward decode
- id_ready  in  1  decode consumes head this cycle
- id_inst  out  32  head instruction
- id_pc  out  32  PC of head instruction

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, FSM=REQ, buffer empty, imem_req=0 while rst_n=0, imem_addr=RESET_PC, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0.
- Reset release: imem_req may assert in the first cycle after release.
- FSM states:
  - REQ: imem_req=1 iff (count + reserved) < DEPTH.
    - gnt with no redirect: pc += 4, tag = old pc, -> WAIT.
  - WAIT: imem_req=0.
    - rvalid: push {tag, rdata}, -> REQ.
  - DROP: imem_req=0.
    - rvalid: discard data, -> REQ.
- Credit: one request outstanding maximum. A granted request reserves one buffer slot until its response returns, so a push never finds the buffer full.
- imem_addr = pc at all times. It is stable while req=1 and no gnt, except on redirect.
- PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect has priority over all other events:
  - pc <= {redirect_pc[31:2], 2'b00}; buffer flushed; id_valid=0 next cycle.
  - From REQ without gnt: stay in REQ; the new address appears next cycle.
  - From REQ with simultaneous gnt: the granted request is in flight -> DROP. pc becomes the redirect target, not +4.
  - From WAIT without rvalid: -> DROP.
  - From WAIT with simultaneous rvalid: the data is discarded -> REQ.
  - From DROP: stay in DROP, pc updated. A simultaneous rvalid is discarded -> REQ.
- Decode handshake:
  - Pop happens when id_valid && id_ready && !redirect.
  - id_inst/id_pc are registered buffer-head outputs. There is no combinational path from imem_rdata or id_ready to any output.
  - A pushed entry is visible on id_valid the cycle after rvalid.
  - Push and pop in the same cycle: both take effect, count unchanged.
  - When empty: id_valid=0, id_inst=NOP, id_pc=0.
- Buffer order is strict FIFO. Pointers wrap modulo DEPTH.
- Mid-operation reset: all state returns to reset values immediately. Any in-flight response after release is ignored, because FSM=REQ treats rvalid as spurious.
- Spurious rvalid in REQ is ignored.
- imem_gnt while imem_req=0 is ignored.

Test Plan:
- Reset then zero-latency-1 memory (gnt every req, rvalid next cycle), id_ready=1 -> imem_addr sequence 0,4,8,C. id_pc matches. id_inst equals memory words in order.
- id_ready=0 for 10 cycles -> buffer fills to 2 entries; imem_req deasserts; no third fetch issued. Release ready -> PCs 0,4 delivered, then fetch resumes at 8.
- gnt withheld 3 cycles -> imem_req stays 1 with imem_addr constant at 0x8 until gnt.
- redirect=1, redirect_pc=0x103 while in WAIT for 0x10 -> late response dropped; next imem_addr=0x100; id_valid low until the 0x100 instruction returns.
- redirect in the same cycle as gnt for 0x20 -> response for 0x20 never reaches decode; next fetch is at the redirect target.
- RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x0. rst_n pulsed low during WAIT -> outputs return to reset values asynchronously.
